rom_image_writer: RTL and testbench

Streams assembled instruction words into a bank of byte-wide program ROM/flash chips, one chip per byte lane. Lane 0 holds bits [LANE_W-1:0], so byte order is little-endian. Generalises the fixed 48-bit, six-ROM image split to any word width and lane count. Adds a serial or parallel lane write mode, programmable strobe timing, optional read-back verify, and overflow/error reporting. Sits between the program loader (word source) and the ROM socket bus.

---
 rtl/rom_writer_pkg.sv | 20 ++
 rtl/rom_strobe_timer.sv | 23 ++
 rtl/rom_image_writer.sv | 196 +++++++++++++++++++
 tb/tb_rom_image_writer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_writer_pkg.sv
// rtl/rom_writer_pkg.sv - shared FSM states, default timing constants and lane slice helper
package rom_writer_pkg;

  localparam int DEF_LANE_W    = 8;
  localparam int DEF_WE_CYCLES = 4;
  localparam int DEF_RD_CYCLES = 2;
  localparam int MAX_WORD_W    = 256;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_RDWAIT, S_CHECK, S_DONE, S_ERROR
  } state_e;

  // Lane k lands in the low bits; caller truncates to its lane width.
  function automatic logic [MAX_WORD_W-1:0] lane_slice(input logic [MAX_WORD_W-1:0] w,
                                                        input int unsigned k,
                                                        input int unsigned lane_w);
    return w >> (k * lane_w);
  endfunction

endpackage

// File: rtl/rom_strobe_timer.sv
// rtl/rom_strobe_timer.sv - loadable down-counter timing the write strobe and read-back wait
module rom_strobe_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // Loading N gives N cycles in the timed state, the last one flagged by expire_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i - W'(1);
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/rom_image_writer.sv
// rtl/rom_image_writer.sv - streams instruction words into byte-lane ROM chips with optional verify
module rom_image_writer
  import rom_writer_pkg::*;
#(
  parameter int WORD_W    = 48,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int WE_CYCLES = DEF_WE_CYCLES,
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  localparam int LANES    = WORD_W / LANE_W,
  localparam int LANE_IW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              par_mode_i,
  input  logic              verify_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_word_i,
  input  logic              in_last_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [WORD_W-1:0] rom_wdata_o,
  input  logic [WORD_W-1:0] rom_rdata_i,
  output logic [LANES-1:0]  rom_lane_sel_o,
  output logic              rom_we_n_o,
  output logic              rom_oe_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              err_overflow_o,
  output logic [LANE_IW-1:0] err_lane_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(((WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES) + 1);

  state_e              state_q, state_d;
  logic                par_q, par_d, ver_q, ver_d, last_q, last_d, ovf_q, ovf_d;
  logic [LANE_IW-1:0]  lane_q, lane_d, err_lane_q, err_lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                tmr_load, tmr_expire, advance, full;
  logic [TMR_W-1:0]    tmr_val;
  logic [LANES-1:0]    lane_sel, mism;
  logic [LANE_IW-1:0]  first_bad;

  rom_strobe_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  assign full = (wcnt_q == CNT_W'(DEPTH));

  always_comb begin
    lane_sel = '0;
    if (state_q inside {S_SETUP, S_PULSE, S_HOLD, S_RDWAIT, S_CHECK})
      lane_sel = par_q ? '1 : (LANES'(1) << lane_q);
  end

  // Only chips enabled for this strobe take part in the read-back compare.
  always_comb begin
    mism      = '0;
    first_bad = '0;
    for (int k = 0; k < LANES; k++)
      mism[k] = lane_sel[k] &&
                (LANE_W'(lane_slice(MAX_WORD_W'(wdata_q), k, LANE_W)) !=
                 LANE_W'(lane_slice(MAX_WORD_W'(rom_rdata_i), k, LANE_W)));
    for (int k = LANES - 1; k >= 0; k--)
      if (mism[k]) first_bad = LANE_IW'(k);
  end

  always_comb begin
    state_d    = state_q;
    par_d      = par_q;
    ver_d      = ver_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    lane_d     = lane_q;
    err_lane_d = err_lane_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wcnt_d     = wcnt_q;
    tmr_load   = 1'b0;
    tmr_val    = TMR_W'(WE_CYCLES);
    advance    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start_i) begin
        par_d      = par_mode_i;
        ver_d      = verify_i;
        addr_d     = '0;
        wcnt_d     = '0;
        ovf_d      = 1'b0;
        err_lane_d = '0;
        state_d    = S_LOAD;
      end
      S_LOAD: if (in_valid_i) begin
        if (full) begin
          ovf_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          wdata_d = in_word_i;
          last_d  = in_last_i;
          lane_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_load = 1'b1;
        state_d  = S_PULSE;
      end
      S_PULSE: if (tmr_expire) state_d = S_HOLD;
      S_HOLD: begin
        if (ver_q) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(RD_CYCLES);
          state_d  = S_RDWAIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_RDWAIT: if (tmr_expire) state_d = S_CHECK;
      S_CHECK: begin
        if (|mism) begin
          err_lane_d = first_bad;
          state_d    = S_ERROR;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!par_q && lane_q != LANE_IW'(LANES - 1)) begin
        lane_d  = lane_q + LANE_IW'(1);
        state_d = S_SETUP;
      end else begin
        wcnt_d = wcnt_q + CNT_W'(1);
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          // Saturate rather than wrap; the overflow check stops the image first.
          if (addr_q != '1) addr_d = addr_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      par_q      <= 1'b0;
      ver_q      <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      lane_q     <= '0;
      err_lane_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      par_q      <= par_d;
      ver_q      <= ver_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      lane_q     <= lane_d;
      err_lane_q <= err_lane_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign in_ready_o     = (state_q == S_LOAD) && !full;
  assign rom_addr_o     = addr_q;
  assign rom_wdata_o    = wdata_q;
  assign rom_lane_sel_o = lane_sel;
  assign rom_we_n_o     = (state_q != S_PULSE);
  assign rom_oe_n_o     = !(state_q inside {S_RDWAIT, S_CHECK});
  assign busy_o         = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done_o         = (state_q == S_DONE);
  assign error_o        = (state_q == S_ERROR);
  assign err_overflow_o = ovf_q;
  assign err_lane_o     = err_lane_q;
  assign word_count_o   = wcnt_q;

endmodule

// File: tb/tb_rom_image_writer.sv
// tb/tb_rom_image_writer.sv - directed bench with loopback ROM model and strobe/latency scoreboard
module tb_rom_image_writer;

  localparam int WORD_W = 48, LANE_W = 8, LANES = 6, ADDR_W = 4, DEPTH = 10;
  localparam int WE_C = 4, RD_C = 2;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              start = 0, par_mode = 0, verify = 0, in_valid = 0, in_last = 0;
  logic [WORD_W-1:0] in_word = '0, rom_rdata;
  logic              in_ready, rom_we_n, rom_oe_n, busy, done, error, err_ovf;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_wdata;
  logic [LANES-1:0]  rom_lane_sel;
  logic [2:0]        err_lane;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  rom_image_writer #(.WORD_W(WORD_W), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .WE_CYCLES(WE_C), .RD_CYCLES(RD_C)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .par_mode_i(par_mode), .verify_i(verify),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_word_i(in_word), .in_last_i(in_last),
    .rom_addr_o(rom_addr), .rom_wdata_o(rom_wdata), .rom_rdata_i(rom_rdata),
    .rom_lane_sel_o(rom_lane_sel), .rom_we_n_o(rom_we_n), .rom_oe_n_o(rom_oe_n),
    .busy_o(busy), .done_o(done), .error_o(error), .err_overflow_o(err_ovf),
    .err_lane_o(err_lane), .word_count_o(word_count)
  );

  int n_vec = 0, n_bad = 0;
  bit m_par, m_ver, fault = 0;
  int img_id = 0, seen_id = 0;
  logic [WORD_W-1:0] exp_w[$];
  int n_strobe, n_hs, we_len, hs_since;
  bit hs_pend;
  logic [7:0] mem [16][LANES];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] pat(input int i);
    return 48'h1122_3344_5566 + 48'(i) * 48'h0101_0101_0101;
  endfunction

  function automatic logic [WORD_W-1:0] mem_word(input int a);
    logic [WORD_W-1:0] w;
    for (int k = 0; k < LANES; k++) w[k*8 +: 8] = mem[a][k];
    return w;
  endfunction

  always_comb begin
    rom_rdata = '0;
    for (int k = 0; k < LANES; k++)
      rom_rdata[k*8 +: 8] = (fault && rom_addr == 4'd2 && k == 3) ? 8'h00 : mem[rom_addr][k];
  end

  // Scoreboard: strobe sequence, strobe width, per-word latency and bus exclusivity.
  always @(negedge clk) begin
    int widx, lane, lat;
    if (img_id != seen_id) begin
      seen_id = img_id; n_strobe = 0; n_hs = 0; hs_pend = 0; we_len = 0;
      for (int a = 0; a < 16; a++) for (int k = 0; k < LANES; k++) mem[a][k] = 8'h5A;
    end
    if (!rst_n) begin
      we_len = 0; hs_pend = 0;
    end else begin
      chk("we_oe_overlap", 64'(!rom_we_n && !rom_oe_n), 0);
      if (in_ready || done || error || !busy) chk("lanesel_idle", 64'(rom_lane_sel), 0);
      if (!rom_we_n) begin
        if (we_len == 0) begin
          widx = m_par ? n_strobe : n_strobe / LANES;
          lane = n_strobe % LANES;
          chk("strobe_addr", 64'(rom_addr), 64'(widx));
          chk("strobe_sel", 64'(rom_lane_sel), m_par ? 64'h3f : 64'(1) << lane);
          if (widx < exp_w.size()) chk("strobe_data", 64'(rom_wdata), 64'(exp_w[widx]));
          else chk("strobe_extra", 64'(widx), 64'(exp_w.size()));
          for (int k = 0; k < LANES; k++)
            if (rom_lane_sel[k]) mem[rom_addr][k] = rom_wdata[k*8 +: 8];
          n_strobe++;
        end
        we_len++;
      end else if (we_len != 0) begin
        chk("strobe_width", 64'(we_len), WE_C);
        we_len = 0;
      end
      if (hs_pend) begin
        hs_since++;
        if (in_ready) begin
          lat = (m_par ? 1 : LANES) * (2 + WE_C + (m_ver ? RD_C + 1 : 0)) + 1;
          chk("word_latency", 64'(hs_since), 64'(lat));
          hs_pend = 0;
        end
      end
      if (in_valid && in_ready) begin
        n_hs++; hs_pend = 1; hs_since = 0;
      end
    end
  end

  task automatic begin_image(input bit par, input bit ver);
    m_par = par; m_ver = ver; img_id++;
    par_mode = par; verify = ver; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input bit last, input bit gappy,
                           input int max, output bit ok);
    ok = 0;
    if (gappy) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    in_word = w; in_last = last; in_valid = 1;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_end(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (done || error) ok = 1;
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_we_n"}, 64'(rom_we_n), 1);
    chk({p, "_oe_n"}, 64'(rom_oe_n), 1);
    chk({p, "_sel"}, 64'(rom_lane_sel), 0);
    chk({p, "_addr"}, 64'(rom_addr), 0);
    chk({p, "_wdata"}, 64'(rom_wdata), 0);
    chk({p, "_ready"}, 64'(in_ready), 0);
    chk({p, "_flags"}, {60'd0, busy, done, error, err_ovf}, 0);
    chk({p, "_err_lane"}, 64'(err_lane), 0);
    chk({p, "_count"}, 64'(word_count), 0);
  endtask

  task automatic load_t1_words();
    exp_w.delete();
    for (int i = 0; i < 8; i++) exp_w.push_back(pat(i));
    exp_w.push_back(48'h0000_0000_FFFF);
  endtask

  task automatic check_image(input string p);
    for (int i = 0; i < exp_w.size(); i++) chk({p, "_mem"}, 64'(mem_word(i)), 64'(exp_w[i]));
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Serial, no verify
    load_t1_words();
    begin_image(0, 0);
    for (int i = 0; i < 9; i++) begin
      send_word(exp_w[i], i == 8, 0, 100, ok);
      chk("t1_handshake", 64'(ok), 1);
    end
    wait_end(100, ok);
    chk("t1_end", 64'(ok), 1);
    chk("t1_flags", {61'd0, busy, done, error}, 64'b010);
    chk("t1_count", 64'(word_count), 9);
    chk("t1_strobes", 64'(n_strobe), 54);
    chk("t1_last_word", 64'(mem_word(8)), 64'h0000_0000_FFFF);
    check_image("t1");

    // Parallel with verify
    begin_image(1, 1);
    for (int i = 0; i < 9; i++) begin
      send_word(exp_w[i], i == 8, 0, 100, ok);
      chk("t2_handshake", 64'(ok), 1);
    end
    wait_end(100, ok);
    chk("t2_end", 64'(ok), 1);
    chk("t2_flags", {61'd0, busy, done, error}, 64'b010);
    chk("t2_strobes", 64'(n_strobe), 9);
    check_image("t2");

    // Verify mismatch: lane 3 of address 2 reads back zero
    fault = 1;
    begin_image(0, 1);
    for (int i = 0; i < 3; i++) begin
      send_word(exp_w[i], 0, 0, 200, ok);
      chk("t3_handshake", 64'(ok), 1);
    end
    wait_end(200, ok);
    chk("t3_end", 64'(ok), 1);
    chk("t3_flags", {60'd0, busy, done, error, err_ovf}, 64'b0010);
    chk("t3_err_lane", 64'(err_lane), 3);
    chk("t3_addr", 64'(rom_addr), 2);
    chk("t3_count", 64'(word_count), 2);
    chk("t3_strobes", 64'(n_strobe), 16);
    send_word(exp_w[3], 0, 0, 20, ok);
    chk("t3_no_accept", 64'(ok), 0);
    chk("t3_no_more_strobes", 64'(n_strobe), 16);
    fault = 0;

    // Overflow: DEPTH words then one more without in_last
    exp_w.delete();
    for (int i = 0; i < 11; i++) exp_w.push_back(pat(i));
    begin_image(1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(exp_w[i], 0, 0, 100, ok);
      chk("t4_handshake", 64'(ok), 1);
    end
    send_word(exp_w[10], 0, 0, 20, ok);
    chk("t4_no_accept", 64'(ok), 0);
    chk("t4_flags", {60'd0, busy, done, error, err_ovf}, 64'b0011);
    chk("t4_count", 64'(word_count), 10);
    chk("t4_addr", 64'(rom_addr), 10);
    chk("t4_hs", 64'(n_hs), 10);
    chk("t4_strobes", 64'(n_strobe), 10);

    // Reset in the middle of a write strobe
    load_t1_words();
    begin_image(0, 0);
    send_word(exp_w[0], 0, 0, 100, ok);
    for (int i = 0; i < 50 && rom_we_n; i++) @(negedge clk);
    chk("t5_in_pulse", 64'(rom_we_n), 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check_reset("t5");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Rewrite from address 0 with gaps and a start pulse during a strobe
    begin_image(0, 0);
    for (int i = 0; i < 9; i++) begin
      send_word(exp_w[i], i == 8, 1, 200, ok);
      chk("t6_handshake", 64'(ok), 1);
      if (i == 1) begin
        for (int j = 0; j < 50 && rom_we_n; j++) @(negedge clk);
        @(posedge clk); #1;
        par_mode = 1; start = 1;
        @(posedge clk); #1;
        start = 0; par_mode = 0;
      end
    end
    wait_end(100, ok);
    chk("t6_end", 64'(ok), 1);
    chk("t6_flags", {61'd0, busy, done, error}, 64'b010);
    chk("t6_count", 64'(word_count), 9);
    chk("t6_hs", 64'(n_hs), 9);
    chk("t6_strobes", 64'(n_strobe), 54);
    check_image("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
